round_ctl: RTL and testbench

Round controller for the reaction game; sits directly upstream of the scorer and drives its winrnd, right and leds_on inputs. Each round it waits a pseudo-random delay with the lights off, then lights the LEDs. It reports the first player push as a one-cycle winrnd pulse, with leds_on and right valid in that same cycle. It stops issuing rounds once the game is over.

---
 rtl/round_ctl.sv | 152 +++++++++++++++
 tb/tb_round_ctl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/round_ctl.sv
// Round controller for the reaction game: random lights-off delay, lit window,
// first-push decision reported as a one-cycle winrnd pulse to the scorer.
module round_ctl #(
    parameter int unsigned MIN_DLY = 16,
    parameter int unsigned LIT_MAX = 200,
    parameter int unsigned GAP     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push_l,
    input  logic push_r,
    input  logic game_over,
    output logic leds_on,
    output logic winrnd,
    output logic right
);

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned DLY_W  = 9;
    localparam int unsigned LIT_W  = 16;
    localparam int unsigned GAP_W  = 8;

    typedef enum logic [2:0] {
        S_ARM,
        S_WAIT,
        S_LIT,
        S_REPORT,
        S_GAP,
        S_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
    logic [LIT_W-1:0]   lit_cnt_q, lit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               tie_q, tie_d;
    logic               leds_on_q, leds_on_d;
    logic               winrnd_q, winrnd_d;
    logic               right_q, right_d;

    logic               any_push_c;
    logic               both_push_c;
    logic               winner_right_c;

    // Simultaneous pushes are settled by an alternating tie flop
    always_comb begin
        any_push_c     = push_l | push_r;
        both_push_c    = push_l & push_r;
        winner_right_c = both_push_c ? tie_q : push_r;
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        dly_cnt_d = dly_cnt_q;
        lit_cnt_d = lit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        tie_d     = tie_q;
        leds_on_d = leds_on_q;
        winrnd_d  = 1'b0;
        right_d   = 1'b0;

        if (game_over) begin
            // A pulse already on the outputs is left to finish this cycle
            state_d   = S_OVER;
            leds_on_d = 1'b0;
        end else begin
            unique case (state_q)
                S_ARM: begin
                    leds_on_d = 1'b0;
                    if (!any_push_c) begin
                        dly_cnt_d = DLY_W'(MIN_DLY) + DLY_W'(lfsr_q);
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT, S_LIT: begin
                    if (any_push_c) begin
                        state_d   = S_REPORT;
                        winrnd_d  = 1'b1;
                        right_d   = winner_right_c;
                        leds_on_d = (state_q == S_LIT);
                        if (both_push_c) begin
                            tie_d = ~tie_q;
                        end
                    end else if (state_q == S_WAIT) begin
                        dly_cnt_d = dly_cnt_q - DLY_W'(1);
                        if (dly_cnt_q == DLY_W'(1)) begin
                            state_d   = S_LIT;
                            leds_on_d = 1'b1;
                            lit_cnt_d = LIT_W'(LIT_MAX);
                        end
                    end else begin
                        lit_cnt_d = lit_cnt_q - LIT_W'(1);
                        if (lit_cnt_q == LIT_W'(1)) begin
                            state_d   = S_ARM;
                            leds_on_d = 1'b0;
                        end
                    end
                end
                S_REPORT: begin
                    state_d   = S_GAP;
                    leds_on_d = 1'b0;
                    gap_cnt_d = GAP_W'(GAP);
                end
                S_GAP: begin
                    leds_on_d = 1'b0;
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    if (gap_cnt_q == GAP_W'(1)) begin
                        state_d = S_ARM;
                    end
                end
                S_OVER: begin
                    leds_on_d = 1'b0;
                end
                default: begin
                    state_d   = S_ARM;
                    leds_on_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_ARM;
            lfsr_q    <= LFSR_W'(8'h01);
            dly_cnt_q <= '0;
            lit_cnt_q <= '0;
            gap_cnt_q <= '0;
            tie_q     <= 1'b0;
            leds_on_q <= 1'b0;
            winrnd_q  <= 1'b0;
            right_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            dly_cnt_q <= dly_cnt_d;
            lit_cnt_q <= lit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            tie_q     <= tie_d;
            leds_on_q <= leds_on_d;
            winrnd_q  <= winrnd_d;
            right_q   <= right_d;
        end
    end

    assign leds_on = leds_on_q;
    assign winrnd  = winrnd_q;
    assign right   = right_q;

endmodule

// File: tb/tb_round_ctl.sv
// Directed bench for round_ctl: delay timing, lit timeout, push reporting,
// tie alternation, held buttons, game over and asynchronous reset.
module tb_round_ctl;

    localparam int unsigned MIN_DLY = 4;
    localparam int unsigned LIT_MAX = 20;
    localparam int unsigned GAP     = 3;

    logic clk;
    logic rst;
    logic push_l;
    logic push_r;
    logic game_over;
    logic leds_on;
    logic winrnd;
    logic right;

    logic [7:0] m_lfsr;
    int n_checks;
    int n_errors;

    round_ctl #(
        .MIN_DLY(MIN_DLY),
        .LIT_MAX(LIT_MAX),
        .GAP    (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push_l   (push_l),
        .push_r   (push_r),
        .game_over(game_over),
        .leds_on  (leds_on),
        .winrnd   (winrnd),
        .right    (right)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR, tracks the design's free-running sequence
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 8'h01;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From an ARM cycle with buttons low, LEDs light after the ARM exit edge plus n WAIT cycles
    task automatic to_lit(input string tag, input int exp_n);
        int cnt;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!leds_on && cnt < 400);
        check(tag, cnt, exp_n + 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int cnt;
        int win_seen;
        int led_seen;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        push_l    = 1'b0;
        push_r    = 1'b0;
        game_over = 1'b0;
        ticks(3);
        check("rst_leds", leds_on, 0);
        check("rst_win", winrnd, 0);
        check("rst_right", right, 0);
        rst = 1'b1;

        // 1: delay from lfsr=01, then abandoned lit window
        to_lit("t1_rise", MIN_DLY + 1);
        cnt = 0;
        win_seen = 0;
        do begin
            tick();
            cnt++;
            if (winrnd) win_seen++;
        end while (leds_on && cnt < 100);
        check("t1_lit_len", cnt, LIT_MAX);
        check("t1_nowin", win_seen, 0);

        // 2: right push three cycles into LIT
        to_lit("t2_rise", MIN_DLY + m_lfsr);
        ticks(3);
        push_r = 1'b1;
        tick();
        push_r = 1'b0;
        check("t2_win", winrnd, 1);
        check("t2_right", right, 1);
        check("t2_leds", leds_on, 1);
        tick();
        check("t2_win_off", winrnd, 0);
        check("t2_leds_off", leds_on, 0);
        ticks(GAP);

        // 3: jump during WAIT; ARM re-entry timing checked via the pre-jump delay
        tick();
        check("t3_wait_leds", leds_on, 0);
        push_l = 1'b1;
        tick();
        push_l = 1'b0;
        check("t3_win", winrnd, 1);
        check("t3_right", right, 0);
        check("t3_leds", leds_on, 0);
        led_seen = 0;
        for (int i = 0; i < 1 + GAP; i++) begin
            tick();
            if (leds_on) led_seen++;
        end
        check("t3_noleds", led_seen, 0);

        // 4: simultaneous pushes in two rounds alternate the winner
        to_lit("t4a_rise", MIN_DLY + m_lfsr);
        push_l = 1'b1;
        push_r = 1'b1;
        tick();
        push_l = 1'b0;
        push_r = 1'b0;
        check("t4a_win", winrnd, 1);
        check("t4a_right", right, 0);
        ticks(1 + GAP);
        to_lit("t4b_rise", MIN_DLY + m_lfsr);
        push_l = 1'b1;
        push_r = 1'b1;
        tick();
        push_l = 1'b0;
        push_r = 1'b0;
        check("t4b_win", winrnd, 1);
        check("t4b_right", right, 1);
        ticks(1 + GAP);

        // 5: held button blocks re-arming until release
        to_lit("t5_rise", MIN_DLY + m_lfsr);
        push_r = 1'b1;
        tick();
        check("t5_win", winrnd, 1);
        win_seen = 0;
        led_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (winrnd) win_seen++;
            if (leds_on) led_seen++;
        end
        check("t5_hold_win", win_seen, 0);
        check("t5_hold_leds", led_seen, 0);
        push_r = 1'b0;
        to_lit("t5_release", MIN_DLY + m_lfsr);

        // 6a: game over during LIT is terminal
        game_over = 1'b1;
        tick();
        check("t6a_leds", leds_on, 0);
        check("t6a_win", winrnd, 0);
        check("t6a_right", right, 0);
        game_over = 1'b0;
        win_seen = 0;
        led_seen = 0;
        for (int i = 0; i < 300; i++) begin
            push_r = (i % 50 == 10);
            tick();
            if (winrnd) win_seen++;
            if (leds_on) led_seen++;
        end
        push_r = 1'b0;
        check("t6a_over_win", win_seen, 0);
        check("t6a_over_leds", led_seen, 0);

        // 6b: reset leaves OVER, then an asynchronous reset mid-LIT
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
        to_lit("t6b_restart1", MIN_DLY + 1);
        ticks(2);
        #3;
        rst = 1'b0;
        #1;
        check("t6b_async_leds", leds_on, 0);
        check("t6b_async_win", winrnd, 0);
        tick();
        rst = 1'b1;
        to_lit("t6b_restart2", MIN_DLY + 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
